// File: rtl/in_buf_pkg.sv
// Shared constants and types for the accelerator input buffer and its DMA.
package in_buf_pkg;

    localparam int                        ACCEL_DATA_WIDTH = 256;
    localparam int                        ACCEL_ID_WIDTH   = 8;
    localparam logic [ACCEL_ID_WIDTH-1:0] ACCEL_IN_ID      = 8'h80;
    localparam int                        ACCEL_OUT_WIDTH  = 32;
    localparam int                        ACCEL_IN_DEPTH   = 16;

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } ser_state_t;

    // A beat of a single slice still needs a 1-bit slice counter.
    function automatic int slice_bits(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/in_buf_sync_fifo.sv
// Beat FIFO with registered level; a push into a full FIFO is silently dropped.
module sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [$clog2(DEPTH+1)-1:0]   level_next,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full & ~clr;
    assign pop_ok  = pop & ~empty & ~clr;
    assign rd_data = mem[rd_ptr];

    assign level_next = clr ? '0 : (level + LW'(push_ok) - LW'(pop_ok));

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; level never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_next;
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/in_buf.sv
// Accelerator input buffer: filters AXI R beats by ID, queues them and
// serialises each beat into OUT_WIDTH words, least significant slice first.
module in_buf
    import in_buf_pkg::*;
#(
    parameter int                  DATA_WIDTH = ACCEL_DATA_WIDTH,
    parameter int                  OUT_WIDTH  = ACCEL_OUT_WIDTH,
    parameter int                  DEPTH      = ACCEL_IN_DEPTH,
    parameter int                  ID_WIDTH   = ACCEL_ID_WIDTH,
    parameter logic [ID_WIDTH-1:0] ID         = ACCEL_IN_ID
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic [ID_WIDTH-1:0]          rid,
    input  logic [DATA_WIDTH-1:0]        rdata,
    input  logic                         rvalid,
    input  logic                         rready,
    output logic                         in_buf_wr_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    localparam int            RATIO      = DATA_WIDTH / OUT_WIDTH;
    localparam int            SW         = slice_bits(RATIO);
    localparam int            LW         = $clog2(DEPTH + 1);
    localparam logic [SW-1:0] LAST_SLICE = SW'(RATIO - 1);

    ser_state_t             state;
    logic [SW-1:0]          slice;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [DATA_WIDTH-1:0]  head;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LW-1:0]          level_next;

    assign push = rvalid & rready & (rid == ID);

    // Reload on the last slice's handshake so consecutive beats stream without a bubble.
    assign pop = ~clr & ~fifo_empty &
                 ((state == EMPTY) |
                  ((state == LOADED) & out_ready & (slice == LAST_SLICE)));

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .push       (push),
        .pop        (pop),
        .wr_data    (rdata),
        .rd_data    (head),
        .level      (level),
        .level_next (level_next),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Held low through reset so the DMA cannot issue a beat before the first edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_buf_wr_ready <= 1'b0;
        end else begin
            in_buf_wr_ready <= (level_next < LW'(DEPTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (clr) begin
            overflow <= 1'b0;
        end else if (push && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            slice     <= '0;
            shreg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            state     <= EMPTY;
            slice     <= '0;
            shreg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (pop) begin
                        state     <= LOADED;
                        slice     <= '0;
                        out_data  <= head[OUT_WIDTH-1:0];
                        shreg     <= head >> OUT_WIDTH;
                        out_valid <= 1'b1;
                    end
                end
                LOADED: begin
                    if (out_ready) begin
                        if (slice == LAST_SLICE) begin
                            if (pop) begin
                                slice     <= '0;
                                out_data  <= head[OUT_WIDTH-1:0];
                                shreg     <= head >> OUT_WIDTH;
                                out_valid <= 1'b1;
                            end else begin
                                state     <= EMPTY;
                                slice     <= '0;
                                out_valid <= 1'b0;
                            end
                        end else begin
                            slice    <= slice + SW'(1);
                            out_data <= shreg[OUT_WIDTH-1:0];
                            shreg    <= shreg >> OUT_WIDTH;
                        end
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_in_buf.sv
// Self-checking bench for in_buf: directed steps plus a randomized DMA/core
// phase scored against a queue of expected output words.
module tb_in_buf;

    localparam int             DW    = 256;
    localparam int             OW    = 32;
    localparam int             DEPTH = 16;
    localparam int             IW    = 8;
    localparam int             RATIO = DW / OW;
    localparam int             LW    = $clog2(DEPTH + 1);
    localparam logic [IW-1:0]  ID    = 8'h80;

    logic           clk = 1'b0;
    logic           rst;
    logic           clr;
    logic [IW-1:0]  rid;
    logic [DW-1:0]  rdata;
    logic           rvalid;
    logic           rready;
    logic           in_buf_wr_ready;
    logic [OW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic [LW-1:0]  level;
    logic           overflow;

    int             checks   = 0;
    int             failures = 0;
    int             consumed = 0;
    logic [OW-1:0]  exp_words[$];
    bit             drop_beat = 1'b0;
    bit             trace_on  = 1'b0;
    bit             valid_trace[$];
    logic [DW-1:0]  beat;
    int             first_v;
    int             last_v;
    int             ones;

    always #5 clk = ~clk;

    in_buf dut (
        .clk             (clk),
        .rst             (rst),
        .clr             (clr),
        .rid             (rid),
        .rdata           (rdata),
        .rvalid          (rvalid),
        .rready          (rready),
        .in_buf_wr_ready (in_buf_wr_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .level           (level),
        .overflow        (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the word handshake and record accepted beats, then advance.
    task automatic tick();
        if (trace_on) valid_trace.push_back(out_valid);
        if (out_valid && out_ready) begin
            consumed++;
            if (exp_words.size() == 0) check("unexpected_word", 64'(out_data), 64'hDEAD_0000_0000);
            else check("word_order", 64'(out_data), 64'(exp_words.pop_front()));
        end
        if (!rst && !clr && rvalid && rready && rid == ID && !drop_beat)
            for (int i = 0; i < RATIO; i++) exp_words.push_back(rdata[i*OW +: OW]);
        @(posedge clk);
        #1;
        if (rst || clr) exp_words.delete();
    endtask

    task automatic push_beat(input logic [IW-1:0] id, input logic [DW-1:0] d);
        rvalid = 1'b1;
        rready = 1'b1;
        rid    = id;
        rdata  = d;
        tick();
        rvalid = 1'b0;
        rready = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 400 && (exp_words.size() != 0 || out_valid); i++) tick();
        check({tag, "_words_left"}, 64'(exp_words.size()), 64'd0);
        check({tag, "_valid_idle"}, 64'(out_valid), 64'd0);
        check({tag, "_level_idle"}, 64'(level), 64'd0);
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < RATIO; i++) r[i*OW +: OW] = $urandom;
        return r;
    endfunction

    initial begin
        rst = 1'b0; clr = 1'b0; rvalid = 1'b0; rready = 1'b0;
        rid = '0; rdata = '0; out_ready = 1'b0;

        // Reset held for three edges; wr_ready rises one edge after release.
        #2 rst = 1'b1;
        #1;
        check("rst_wr_ready", 64'(in_buf_wr_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        repeat (3) tick();
        check("rst_hold_wr_ready", 64'(in_buf_wr_ready), 64'd0);
        rst = 1'b0;
        check("rel_wr_ready_same", 64'(in_buf_wr_ready), 64'd0);
        tick();
        check("rel_wr_ready", 64'(in_buf_wr_ready), 64'd1);
        check("rel_out_valid", 64'(out_valid), 64'd0);

        // Single beat of known words, consumed at full rate.
        for (int i = 0; i < RATIO; i++) beat[i*OW +: OW] = OW'(32'hA0 + i);
        out_ready = 1'b1;
        push_beat(ID, beat);
        check("t2_valid_after_push", 64'(out_valid), 64'd0);
        check("t2_level_after_push", 64'(level), 64'd1);
        tick();
        for (int k = 0; k < RATIO; k++) begin
            check("t2_valid", 64'(out_valid), 64'd1);
            check("t2_word", 64'(out_data), 64'(32'hA0 + k));
            tick();
        end
        check("t2_valid_end", 64'(out_valid), 64'd0);
        check("t2_level_end", 64'(level), 64'd0);

        // Foreign ID must be ignored.
        push_beat(8'h81, rand_beat());
        check("t3_level", 64'(level), 64'd0);
        tick();
        check("t3_valid", 64'(out_valid), 64'd0);

        // Fill with the core stalled, overflow, then drain.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_beat(ID, rand_beat());
        check("t4_level_15", 64'(level), 64'd15);
        check("t4_wr_ready_15", 64'(in_buf_wr_ready), 64'd1);
        check("t4_valid_stalled", 64'(out_valid), 64'd1);
        push_beat(ID, rand_beat());
        check("t4_level_full", 64'(level), 64'd16);
        check("t4_wr_ready_full", 64'(in_buf_wr_ready), 64'd0);
        check("t4_overflow_pre", 64'(overflow), 64'd0);
        drop_beat = 1'b1;
        push_beat(ID, rand_beat());
        drop_beat = 1'b0;
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_level_still_full", 64'(level), 64'd16);
        out_ready = 1'b1;
        repeat (RATIO - 1) tick();
        check("t4_wr_ready_before_pop", 64'(in_buf_wr_ready), 64'd0);
        check("t4_level_before_pop", 64'(level), 64'd16);
        tick();
        check("t4_wr_ready_after_pop", 64'(in_buf_wr_ready), 64'd1);
        check("t4_level_after_pop", 64'(level), 64'd15);
        drain("t4_drain");
        check("t4_overflow_sticky", 64'(overflow), 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_clr_overflow", 64'(overflow), 64'd0);
        check("t4_clr_wr_ready", 64'(in_buf_wr_ready), 64'd1);

        // Back-to-back burst must stream 32 words with no gaps.
        valid_trace.delete();
        trace_on = 1'b1;
        rvalid = 1'b1; rready = 1'b1; rid = ID;
        for (int i = 0; i < 4; i++) begin
            rdata = rand_beat();
            tick();
        end
        rvalid = 1'b0; rready = 1'b0;
        repeat (36) tick();
        trace_on = 1'b0;
        first_v = -1; last_v = -1; ones = 0;
        foreach (valid_trace[i]) begin
            if (valid_trace[i]) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                ones++;
            end
        end
        check("t5_valid_words", 64'(ones), 64'd32);
        check("t5_no_gaps", 64'(last_v - first_v + 1), 64'd32);
        check("t5_first_latency", 64'(first_v), 64'd2);

        // Asynchronous reset, then synchronous clear, after word 3 of beat 2.
        for (int pass = 0; pass < 2; pass++) begin
            consumed = 0;
            out_ready = 1'b1;
            rvalid = 1'b1; rready = 1'b1; rid = ID;
            for (int i = 0; i < 3; i++) begin
                rdata = rand_beat();
                tick();
            end
            rvalid = 1'b0; rready = 1'b0;
            for (int i = 0; i < 40 && consumed < RATIO + 4; i++) tick();
            check("t6_consumed", 64'(consumed), 64'(RATIO + 4));
            if (pass == 0) begin
                rst = 1'b1;
                #1;
                check("t6_rst_valid", 64'(out_valid), 64'd0);
                check("t6_rst_level", 64'(level), 64'd0);
                check("t6_rst_overflow", 64'(overflow), 64'd0);
                tick();
                rst = 1'b0;
                tick();
            end else begin
                clr = 1'b1;
                tick();
                clr = 1'b0;
                check("t6_clr_valid", 64'(out_valid), 64'd0);
                check("t6_clr_level", 64'(level), 64'd0);
                check("t6_clr_overflow", 64'(overflow), 64'd0);
                check("t6_clr_wr_ready", 64'(in_buf_wr_ready), 64'd1);
            end
            check("t6_wr_ready", 64'(in_buf_wr_ready), 64'd1);
            beat = rand_beat();
            push_beat(ID, beat);
            tick();
            check("t6_restart_valid", 64'(out_valid), 64'd1);
            check("t6_restart_word0", 64'(out_data), 64'(beat[OW-1:0]));
            drain("t6_drain");
        end

        // Randomized DMA that honours wr_ready, random IDs, random core stalls and clears.
        for (int c = 0; c < 1500; c++) begin
            rvalid    = in_buf_wr_ready && ($urandom_range(0, 2) != 0);
            rready    = ($urandom_range(0, 3) != 0);
            rid       = ($urandom_range(0, 4) == 0) ? 8'h81 : ID;
            rdata     = rand_beat();
            out_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rvalid = 1'b0; rready = 1'b0; clr = 1'b0;
        drain("rand_drain");
        check("rand_no_overflow", 64'(overflow), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
